exec_md_stage: RTL and testbench
================================

# exec_md_stage

Parametrised execute stage for the five-stage MIPS pipeline. Forwarding muxes feed a single-cycle ALU, and a multi-cycle multiply/divide unit owns the HI/LO registers. Results land in the E/M pipeline register. The block sits between the D/E register and the memory stage and reports a stall request to the hazard unit while HI/LO are being computed.

## Interface
- W, 32, datapath width (≥8, power of two)
- MUL_LAT, 5, cycles from MULT/MULTU acceptance to HI/LO update (≥1)
- DIV_LAT, 10, cycles from DIV/DIVU acceptance to HI/LO update (≥1)
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high
- stall  in  1  hold E/M register; block md acceptance
- flush  in  1  load bubble (all zero) into E/M register; block md acceptance
- fwd_sel_a / fwd_sel_b  in  2  operand source: 0 rf_a/rf_b, 1 m_pc4+4, 2 m_alu, 3 w_wd
- rf_a, rf_b, m_pc4, m_alu, w_wd  in  W  register-file operands and forwarding sources
- imm  in  W  pre-extended immediate
- imm_sel  in  2  ALU B input: 0 forwarded B, 1 imm, 2 HI, 3 LO
- alu_op  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT, 7 SLTU, 8 SLL, 9 SRL, 10 SRA, 11 LUI, 12 PASS_B; others → 0
- md_valid  in  1  md operation present in E
- md_op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; others ignored
- pc_e  in  W  PC of the E instruction
- alu_out_m, data2_m, pc_m  out  W  registered ALU result, forwarded B, PC
- hi, lo  out  W  architectural HI/LO
- md_busy  out  1  md unit counting
- md_stall  out  1  md_busy & (md_valid | imm_sel≥2), combinational

## Operation
- A = selected fwd_sel_a source; Bf = selected fwd_sel_b source; B = imm_sel mux over {Bf, imm, hi, lo}.
- Shifts move B by A[log2(W)-1:0]. LUI = B << W/2. SLT is signed and SLTU unsigned; both yield a 0/1 result. ADD/SUB wrap modulo 2^W.
- E/M register: on flush it loads zeros. Else, when stall is low, it loads {ALU result, Bf, pc_e}. When stall is high it holds. flush has priority over stall.
- Acceptance: accept = md_valid & ~md_busy & ~stall & ~flush.
- MTHI/MTLO: HI (or LO) ← A at the accepting edge. No busy.
- MULT/MULTU: the 2W product of A×B is captured into a pending register at acceptance. The counter loads MUL_LAT and md_busy rises the same edge. At the edge where the counter goes 1→0: HI ← product[2W-1:W], LO ← product[W-1:0], md_busy falls.
- DIV/DIVU: same sequence with DIV_LAT. LO ← quotient, HI ← remainder. Signed division truncates toward zero and the remainder takes the dividend's sign. Divide by zero: LO ← all ones, HI ← A.
- md ops presented while busy are not accepted. They are held upstream via md_stall and accepted on the cycle after busy falls.
- Reset (any time, including mid-operation): E/M outputs, hi, lo, pending and counter are cleared to 0; md_busy goes to 0 and the pending result is discarded.

## Timing
- ALU/forwarding path is combinational. E/M outputs appear one edge after the inputs.
- MULT accepted at edge T: md_busy high for cycles T..T+MUL_LAT-1. hi/lo are valid after edge T+MUL_LAT. The same holds for DIV with DIV_LAT.
- An MFHI/MFLO (imm_sel=2/3, PASS_B) in E during busy raises md_stall. The first non-stalled cycle reads the new value.
- Back-to-back md ops: the second op is accepted at the edge where busy falls +1 cycle. It never overlaps the first.

## Configuration
- EXEC_MD_DIV_EN defined: DIV/DIVU are implemented as above.
- Not defined: no divider is synthesised. DIV/DIVU are ignored: not accepted, HI/LO unchanged, md_busy stays low.

## Test plan
- ALU with forwarding: fwd_sel_a=2, m_alu=0x7, rf_b=0x3, alu_op=SUB → alu_out_m=0x4 one edge later; SLT with A=0xFFFFFFFF, B=1 → 1; SLTU → 0.
- MULT A=0xFFFFFFFE (−2), B=3: md_busy high for exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA; MULTU of the same operands → hi=0x2, lo=0xFFFFFFFA.
- DIV A=−7, B=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF after 10 cycles; DIVU A=5, B=0 → lo=0xFFFFFFFF, hi=5.
- MFLO issued one cycle after MULT: md_stall asserted until busy falls, then alu_out_m = new lo; a second MULT during busy is accepted only after the first completes.
- Reset asserted at cycle 3 of a MULT: md_busy, hi, lo and E/M outputs are 0 immediately, and no later HI/LO update occurs.
- stall=1 with md_valid MULT: not accepted and E/M held; flush=1 → alu_out_m=data2_m=pc_m=0.

Source files
------------

// File: rtl/exec_md_if.sv
// Execute-stage bundle: D/E operands and controls in, E/M results and HI/LO state out.
// Latency: none (wires only).
// Backpressure: stall/flush arrive from the hazard unit; md_stall is returned to it.
interface exec_md_if #(
  parameter int W = 32
);
  logic         stall;
  logic         flush;
  logic [1:0]   fwd_sel_a;
  logic [1:0]   fwd_sel_b;
  logic [W-1:0] rf_a;
  logic [W-1:0] rf_b;
  logic [W-1:0] m_pc4;
  logic [W-1:0] m_alu;
  logic [W-1:0] w_wd;
  logic [W-1:0] imm;
  logic [1:0]   imm_sel;
  logic [3:0]   alu_op;
  logic         md_valid;
  logic [2:0]   md_op;
  logic [W-1:0] pc_e;
  logic [W-1:0] alu_out_m;
  logic [W-1:0] data2_m;
  logic [W-1:0] pc_m;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         md_busy;
  logic         md_stall;

  // Upstream side: D/E register and hazard unit
  modport master (
    output stall, flush, fwd_sel_a, fwd_sel_b, rf_a, rf_b, m_pc4, m_alu, w_wd,
           imm, imm_sel, alu_op, md_valid, md_op, pc_e,
    input  alu_out_m, data2_m, pc_m, hi, lo, md_busy, md_stall
  );

  // Execute stage itself
  modport slave (
    input  stall, flush, fwd_sel_a, fwd_sel_b, rf_a, rf_b, m_pc4, m_alu, w_wd,
           imm, imm_sel, alu_op, md_valid, md_op, pc_e,
    output alu_out_m, data2_m, pc_m, hi, lo, md_busy, md_stall
  );
endinterface

// File: rtl/exec_md_stage.sv
// MIPS execute stage: forwarding muxes, single-cycle ALU, multi-cycle mult/div owning HI/LO.
// Latency: ALU result in E/M one edge later; HI/LO MUL_LAT / DIV_LAT edges after md acceptance.
// Backpressure: md_stall requests a hold while busy; stall holds E/M, flush bubbles it.
// Option: define EXEC_MD_DIV_EN to build the divider; otherwise DIV/DIVU are ignored.
module exec_md_stage #(
  parameter int W       = 32,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input logic       clk,
  input logic       reset,
  exec_md_if.slave  io
);

  localparam int SHW     = $clog2(W);
  localparam int LAT_MAX = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW      = $clog2(LAT_MAX + 1);

  localparam logic [CW-1:0] MUL_CNT = CW'(MUL_LAT);
`ifdef EXEC_MD_DIV_EN
  localparam logic [CW-1:0] DIV_CNT = CW'(DIV_LAT);
`endif

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_NOR  = 4'd5;
  localparam logic [3:0] ALU_SLT  = 4'd6;
  localparam logic [3:0] ALU_SLTU = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;
  localparam logic [3:0] ALU_SRA  = 4'd10;
  localparam logic [3:0] ALU_LUI  = 4'd11;
  localparam logic [3:0] ALU_PASS = 4'd12;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  typedef enum logic {MD_IDLE, MD_BUSY} md_state_t;

  md_state_t      md_state, md_state_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic [2*W-1:0] pend, pend_nxt;
  logic [W-1:0]   hi_q, hi_nxt;
  logic [W-1:0]   lo_q, lo_nxt;

  logic [W-1:0]   op_a, op_bf, op_b, alu_res;
  logic [SHW-1:0] shamt;
  logic           md_busy, accept;
  logic [2*W-1:0] ext_a, ext_b, prod;

  logic [W-1:0]   alu_q, data2_q, pc_q;

  // Operand forwarding and ALU B-input selection
  always_comb begin
    op_a  = io.rf_a;
    op_bf = io.rf_b;
    op_b  = io.rf_b;
    case (io.fwd_sel_a)
      2'd0: op_a = io.rf_a;
      2'd1: op_a = io.m_pc4 + W'(4);
      2'd2: op_a = io.m_alu;
      default: op_a = io.w_wd;
    endcase
    case (io.fwd_sel_b)
      2'd0: op_bf = io.rf_b;
      2'd1: op_bf = io.m_pc4 + W'(4);
      2'd2: op_bf = io.m_alu;
      default: op_bf = io.w_wd;
    endcase
    case (io.imm_sel)
      2'd0: op_b = op_bf;
      2'd1: op_b = io.imm;
      2'd2: op_b = hi_q;
      default: op_b = lo_q;
    endcase
  end

  assign shamt = op_a[SHW-1:0];

  // Single-cycle ALU; unassigned opcodes produce zero
  always_comb begin
    alu_res = '0;
    case (io.alu_op)
      ALU_ADD:  alu_res = op_a + op_b;
      ALU_SUB:  alu_res = op_a - op_b;
      ALU_AND:  alu_res = op_a & op_b;
      ALU_OR:   alu_res = op_a | op_b;
      ALU_XOR:  alu_res = op_a ^ op_b;
      ALU_NOR:  alu_res = ~(op_a | op_b);
      ALU_SLT:  alu_res = {{(W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      ALU_SLTU: alu_res = {{(W-1){1'b0}}, (op_a < op_b)};
      ALU_SLL:  alu_res = op_b << shamt;
      ALU_SRL:  alu_res = op_b >> shamt;
      ALU_SRA:  alu_res = W'($signed(op_b) >>> shamt);
      ALU_LUI:  alu_res = op_b << (W / 2);
      ALU_PASS: alu_res = op_b;
      default:  alu_res = '0;
    endcase
  end

  // E/M pipeline register: flush beats stall, stall holds
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_q   <= '0;
      data2_q <= '0;
      pc_q    <= '0;
    end else if (io.flush) begin
      alu_q   <= '0;
      data2_q <= '0;
      pc_q    <= '0;
    end else if (!io.stall) begin
      alu_q   <= alu_res;
      data2_q <= op_bf;
      pc_q    <= io.pc_e;
    end
  end

  // Full 2W product: sign- or zero-extend both operands, keep the low 2W bits
  always_comb begin
    ext_a = (io.md_op == MD_MULT) ? {{W{op_a[W-1]}}, op_a} : {{W{1'b0}}, op_a};
    ext_b = (io.md_op == MD_MULT) ? {{W{op_b[W-1]}}, op_b} : {{W{1'b0}}, op_b};
    prod  = ext_a * ext_b;
  end

`ifdef EXEC_MD_DIV_EN
  logic           a_neg, b_neg;
  logic [W-1:0]   ua, ub, uq, ur, sq, sr;
  logic [2*W-1:0] div_res;

  // Divide on magnitudes then fix signs, so the most-negative / -1 case is well defined
  always_comb begin
    a_neg = (io.md_op == MD_DIV) & op_a[W-1];
    b_neg = (io.md_op == MD_DIV) & op_b[W-1];
    ua    = a_neg ? -op_a : op_a;
    ub    = b_neg ? -op_b : op_b;
    uq    = '0;
    ur    = '0;
    if (ub != '0) begin
      uq = ua / ub;
      ur = ua % ub;
    end
    sq      = (a_neg ^ b_neg) ? -uq : uq;
    sr      = a_neg ? -ur : ur;
    div_res = (op_b == '0) ? {op_a, {W{1'b1}}} : {sr, sq};
  end
`endif

  assign md_busy = (md_state == MD_BUSY);
  assign accept  = io.md_valid & ~md_busy & ~io.stall & ~io.flush;

  // md unit next state: launch on acceptance, retire into HI/LO when the count expires
  always_comb begin
    md_state_nxt = md_state;
    cnt_nxt      = cnt;
    pend_nxt     = pend;
    hi_nxt       = hi_q;
    lo_nxt       = lo_q;
    case (md_state)
      MD_IDLE: begin
        if (accept) begin
          case (io.md_op)
            MD_MULT, MD_MULTU: begin
              pend_nxt     = prod;
              cnt_nxt      = MUL_CNT;
              md_state_nxt = MD_BUSY;
            end
`ifdef EXEC_MD_DIV_EN
            MD_DIV, MD_DIVU: begin
              pend_nxt     = div_res;
              cnt_nxt      = DIV_CNT;
              md_state_nxt = MD_BUSY;
            end
`endif
            MD_MTHI: hi_nxt = op_a;
            MD_MTLO: lo_nxt = op_a;
            default: ;
          endcase
        end
      end
      default: begin
        cnt_nxt = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          hi_nxt       = pend[2*W-1:W];
          lo_nxt       = pend[W-1:0];
          md_state_nxt = MD_IDLE;
        end
      end
    endcase
  end

  // md unit state register; reset discards any in-flight result
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      md_state <= MD_IDLE;
      cnt      <= '0;
      pend     <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      md_state <= md_state_nxt;
      cnt      <= cnt_nxt;
      pend     <= pend_nxt;
      hi_q     <= hi_nxt;
      lo_q     <= lo_nxt;
    end
  end

  assign io.alu_out_m = alu_q;
  assign io.data2_m   = data2_q;
  assign io.pc_m      = pc_q;
  assign io.hi        = hi_q;
  assign io.lo        = lo_q;
  assign io.md_busy   = md_busy;
  assign io.md_stall  = md_busy & (io.md_valid | io.imm_sel[1]);

endmodule

// File: tb/tb_exec_md_stage.sv
// Directed bench for exec_md_stage (W=32, MUL_LAT=5, DIV_LAT=10).
// Inputs change and outputs are sampled 1ns after the rising edge.
// DIV expectations follow the EXEC_MD_DIV_EN build option.
module tb_exec_md_stage;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;
  int   cyc;

  exec_md_if #(.W(32)) io ();

  exec_md_stage #(.W(32), .MUL_LAT(5), .DIV_LAT(10)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (io.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    io.stall = 0; io.flush = 0; io.fwd_sel_a = 0; io.fwd_sel_b = 0;
    io.rf_a = 0; io.rf_b = 0; io.m_pc4 = 0; io.m_alu = 0; io.w_wd = 0;
    io.imm = 0; io.imm_sel = 0; io.alu_op = 0; io.md_valid = 0; io.md_op = 0;
    io.pc_e = 0;
  endtask

  // ALU op from rf_a/rf_b or immediate, result checked one edge later
  task automatic alu_vec(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [1:0] isel, input logic [31:0] exp);
    io.fwd_sel_a = 0; io.fwd_sel_b = 0; io.rf_a = a; io.rf_b = b; io.imm = b;
    io.imm_sel = isel; io.alu_op = op;
    tick();
    chk(tag, {32'd0, io.alu_out_m}, {32'd0, exp});
  endtask

  // Present one md op until accepted, then count busy cycles until it retires
  task automatic md_vec(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int busy_cycles);
    io.fwd_sel_a = 0; io.fwd_sel_b = 0; io.imm_sel = 0; io.alu_op = 0;
    io.rf_a = a; io.rf_b = b; io.md_op = op; io.md_valid = 1;
    tick();
    io.md_valid = 0;
    busy_cycles = 0;
    while (io.md_busy && busy_cycles < 100) begin
      tick();
      busy_cycles++;
    end
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    idle_inputs();
    reset = 1;
    io.rf_a = 32'h55; io.rf_b = 32'h66; io.pc_e = 32'h77;
    tick();
    tick();
    chk("rst_alu", {32'd0, io.alu_out_m}, 64'h0);
    chk("rst_d2", {32'd0, io.data2_m}, 64'h0);
    chk("rst_pc", {32'd0, io.pc_m}, 64'h0);
    chk("rst_hilo", {io.hi, io.lo}, 64'h0);
    chk("rst_busy", {63'd0, io.md_busy}, 64'h0);
    reset = 0;
    idle_inputs();

    // Forwarded SUB: A from m_alu
    io.fwd_sel_a = 2; io.m_alu = 32'h7; io.rf_b = 32'h3; io.alu_op = 4'd1; io.pc_e = 32'h100;
    #2;
    chk("sub_before_edge", {32'd0, io.alu_out_m}, 64'h0);
    tick();
    chk("sub_fwd", {32'd0, io.alu_out_m}, 64'h4);
    chk("sub_d2", {32'd0, io.data2_m}, 64'h3);
    chk("sub_pc", {32'd0, io.pc_m}, 64'h100);

    // A from m_pc4+4, B from w_wd
    io.fwd_sel_a = 1; io.fwd_sel_b = 3; io.m_pc4 = 32'h1000; io.w_wd = 32'h10; io.alu_op = 4'd0;
    tick();
    chk("add_fwd", {32'd0, io.alu_out_m}, 64'h1014);
    chk("add_fwd_d2", {32'd0, io.data2_m}, 64'h10);

    alu_vec("slt", 4'd6, 32'hFFFF_FFFF, 32'h1, 2'd0, 32'h1);
    alu_vec("sltu", 4'd7, 32'hFFFF_FFFF, 32'h1, 2'd0, 32'h0);
    alu_vec("sll_imm", 4'd8, 32'h4, 32'h8, 2'd1, 32'h80);
    alu_vec("sra", 4'd10, 32'h4, 32'h8000_0000, 2'd0, 32'hF800_0000);
    alu_vec("srl", 4'd9, 32'h24, 32'h8000_0000, 2'd0, 32'h0800_0000);
    alu_vec("lui", 4'd11, 32'h0, 32'h1234, 2'd1, 32'h1234_0000);
    alu_vec("nor", 4'd5, 32'h0F0F_0000, 32'h0000_00FF, 2'd0, 32'hF0F0_FF00);
    alu_vec("bad_op", 4'd13, 32'h1, 32'h2, 2'd0, 32'h0);

    // MULT / MULTU
    md_vec(3'd0, 32'hFFFF_FFFE, 32'h3, cyc);
    chk("mult_busy_cycles", 64'(cyc), 64'd5);
    chk("mult_hilo", {io.hi, io.lo}, 64'hFFFF_FFFF_FFFF_FFFA);
    md_vec(3'd1, 32'hFFFF_FFFE, 32'h3, cyc);
    chk("multu_busy_cycles", 64'(cyc), 64'd5);
    chk("multu_hilo", {io.hi, io.lo}, 64'h0000_0002_FFFF_FFFA);

    // DIV / DIVU
    md_vec(3'd2, 32'hFFFF_FFF9, 32'h2, cyc);
`ifdef EXEC_MD_DIV_EN
    chk("div_busy_cycles", 64'(cyc), 64'd10);
    chk("div_hilo", {io.hi, io.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
`else
    chk("div_busy_cycles", 64'(cyc), 64'd0);
    chk("div_hilo", {io.hi, io.lo}, 64'h0000_0002_FFFF_FFFA);
`endif
    md_vec(3'd3, 32'h5, 32'h0, cyc);
`ifdef EXEC_MD_DIV_EN
    chk("divu0_busy_cycles", 64'(cyc), 64'd10);
    chk("divu0_hilo", {io.hi, io.lo}, 64'h0000_0005_FFFF_FFFF);
`else
    chk("divu0_busy_cycles", 64'(cyc), 64'd0);
    chk("divu0_hilo", {io.hi, io.lo}, 64'h0000_0002_FFFF_FFFA);
`endif

    // MTHI / MTLO take effect at the accepting edge, no busy
    md_vec(3'd4, 32'hCAFE, 32'h0, cyc);
    chk("mthi_busy", 64'(cyc), 64'd0);
    md_vec(3'd5, 32'hBEEF, 32'h0, cyc);
    chk("mthi_mtlo", {io.hi, io.lo}, 64'h0000_CAFE_0000_BEEF);

    // MFLO one cycle after MULT, hazard unit mirrors md_stall onto stall
    io.rf_a = 32'd6; io.rf_b = 32'd7; io.md_op = 3'd0; io.md_valid = 1; io.alu_op = 4'd0;
    tick();
    io.md_valid = 0; io.imm_sel = 2'd3; io.alu_op = 4'd12; io.pc_e = 32'h200;
    chk("mflo_stall_raised", {63'd0, io.md_stall}, 64'h1);
    cyc = 0;
    while (io.md_stall && cyc < 100) begin
      io.stall = 1;
      tick();
      cyc++;
    end
    chk("mflo_stall_cycles", 64'(cyc), 64'd5);
    chk("mflo_em_held", {32'd0, io.alu_out_m}, 64'd13);
    io.stall = 0;
    tick();
    chk("mflo_new_lo", {32'd0, io.alu_out_m}, 64'd42);
    chk("mflo_pc", {32'd0, io.pc_m}, 64'h200);

    // Second MULT presented during busy waits for the first to retire
    io.imm_sel = 0; io.alu_op = 4'd0;
    io.rf_a = 32'd3; io.rf_b = 32'd5; io.md_op = 3'd0; io.md_valid = 1;
    tick();
    io.rf_a = 32'd2; io.rf_b = 32'd9;
    cyc = 0;
    while (io.md_stall && cyc < 100) begin
      io.stall = 1;
      tick();
      cyc++;
    end
    chk("b2b_wait_cycles", 64'(cyc), 64'd5);
    chk("b2b_first_result", {io.hi, io.lo}, 64'd15);
    chk("b2b_idle_between", {63'd0, io.md_busy}, 64'h0);
    io.stall = 0;
    tick();
    chk("b2b_second_accept", {63'd0, io.md_busy}, 64'h1);
    io.md_valid = 0;
    cyc = 0;
    while (io.md_busy && cyc < 100) begin
      tick();
      cyc++;
    end
    chk("b2b_second_result", {io.hi, io.lo}, 64'd18);

    // stall blocks acceptance and holds E/M; flush bubbles even under stall
    io.rf_a = 32'h11; io.rf_b = 32'h22; io.alu_op = 4'd0; io.pc_e = 32'h300;
    tick();
    io.stall = 1; io.md_valid = 1; io.md_op = 3'd0; io.rf_a = 32'h4; io.pc_e = 32'h304;
    tick();
    chk("stall_no_accept", {63'd0, io.md_busy}, 64'h0);
    chk("stall_em_held", {io.alu_out_m, io.pc_m}, 64'h0000_0033_0000_0300);
    io.flush = 1;
    tick();
    chk("flush_em", {io.alu_out_m, io.data2_m}, 64'h0);
    chk("flush_pc", {32'd0, io.pc_m}, 64'h0);
    chk("flush_no_accept", {63'd0, io.md_busy}, 64'h0);
    chk("stall_hilo_kept", {io.hi, io.lo}, 64'd18);
    idle_inputs();

    // Reset in cycle 3 of a MULT
    io.rf_a = 32'h0001_0001; io.rf_b = 32'h0001_0001; io.md_op = 3'd0; io.md_valid = 1;
    tick();
    io.md_valid = 0;
    chk("rstmid_em_loaded", {32'd0, io.alu_out_m}, 64'h0002_0002);
    tick();
    tick();
    reset = 1;
    #1;
    chk("rstmid_busy", {63'd0, io.md_busy}, 64'h0);
    chk("rstmid_hilo", {io.hi, io.lo}, 64'h0);
    chk("rstmid_em", {io.alu_out_m, io.data2_m}, 64'h0);
    tick();
    reset = 0;
    for (int i = 0; i < 10; i++) tick();
    chk("rstmid_no_late_update", {io.hi, io.lo}, 64'h0);
    chk("rstmid_still_idle", {63'd0, io.md_busy}, 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
